// File: rtl/demux1x4_32b_dispatch_pkg.sv
// Shared widths and lane codes for the 1-to-4 word dispatcher.
package demux1x4_32b_dispatch_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LANES = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned OCC_W = 2;

    typedef enum logic [SEL_W-1:0] {
        LANE_A = 2'b00,
        LANE_B = 2'b01,
        LANE_C = 2'b10,
        LANE_D = 2'b11
    } lane_e;

    // One-hot lane enable for a select code.
    function automatic logic [LANES-1:0] lane_onehot(input logic [SEL_W-1:0] sel);
        lane_onehot = LANES'(1) << sel;
    endfunction

endpackage

// File: rtl/demux1x4_32b_dispatch_lane_fifo2.sv
// Two-entry register FIFO for one dispatcher lane, with head output and a
// wrapping count of words delivered to the consumer.
module demux_lane_fifo2
    import demux1x4_32b_dispatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic             full_o,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] mem0_q, mem0_d;
    logic [WIDTH-1:0] mem1_q, mem1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full;
    logic             push;
    logic             pop;

    assign full = (occ_q == OCC_W'(DEPTH));
    assign push = push_i && !full;
    assign pop  = (occ_q != '0) && ready_i;

    // mem0 is always the head; mem1 holds the second entry when occupancy is 2.
    always_comb begin
        occ_d  = occ_q;
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        cnt_d  = cnt_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == '0) begin
                    mem0_d = data_i;
                end else begin
                    mem1_d = data_i;
                end
                occ_d = occ_q + OCC_W'(1);
            end
            2'b01: begin
                mem0_d = mem1_q;
                occ_d  = occ_q - OCC_W'(1);
            end
            2'b11: begin
                mem0_d = data_i;
            end
            default: begin
            end
        endcase
        if (pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q  <= '0;
            mem0_q <= '0;
            mem1_q <= '0;
            cnt_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign valid_o = (occ_q != '0);
    assign full_o  = full;
    assign head_o  = mem0_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux1x4_32b_dispatch.sv
// Registered 1-to-4 dispatcher: steers each accepted word to one of four
// independently buffered output lanes by a 2-bit select code.
module demux1x4_32b_dispatch
    import demux1x4_32b_dispatch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      select,
    output logic [LANES-1:0]      out_valid,
    input  logic [LANES-1:0]      out_ready,
    output logic [WIDTH-1:0]      out_a,
    output logic [WIDTH-1:0]      out_b,
    output logic [WIDTH-1:0]      out_c,
    output logic [WIDTH-1:0]      out_d,
    output logic [CNT_W-1:0]      cnt_a,
    output logic [CNT_W-1:0]      cnt_b,
    output logic [CNT_W-1:0]      cnt_c,
    output logic [CNT_W-1:0]      cnt_d
);

    logic [LANES-1:0] lane_full;
    logic [LANES-1:0] lane_push;
    logic [WIDTH-1:0] lane_head [LANES];
    logic [CNT_W-1:0] lane_cnt  [LANES];

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = !lane_full[select];
    assign lane_push = (in_valid && in_ready) ? lane_onehot(select) : '0;

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        demux_lane_fifo2 u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (lane_push[i]),
            .data_i  (in_data),
            .ready_i (out_ready[i]),
            .valid_o (out_valid[i]),
            .full_o  (lane_full[i]),
            .head_o  (lane_head[i]),
            .cnt_o   (lane_cnt[i])
        );
    end

    assign out_a = lane_head[LANE_A];
    assign out_b = lane_head[LANE_B];
    assign out_c = lane_head[LANE_C];
    assign out_d = lane_head[LANE_D];
    assign cnt_a = lane_cnt[LANE_A];
    assign cnt_b = lane_cnt[LANE_B];
    assign cnt_c = lane_cnt[LANE_C];
    assign cnt_d = lane_cnt[LANE_D];

endmodule

// File: tb/tb_demux1x4_32b_dispatch.sv
// Self-checking bench for the 1-to-4 dispatcher: directed scenarios plus
// random traffic against a queue-based lane model.
module tb_demux1x4_32b_dispatch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  select;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_a, out_b, out_c, out_d;
    logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;

    demux1x4_32b_dispatch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
        .cnt_c     (cnt_c),
        .cnt_d     (cnt_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] dout [4];
    logic [15:0] dcnt [4];
    assign dout[0] = out_a;
    assign dout[1] = out_b;
    assign dout[2] = out_c;
    assign dout[3] = out_d;
    assign dcnt[0] = cnt_a;
    assign dcnt[1] = cnt_b;
    assign dcnt[2] = cnt_c;
    assign dcnt[3] = cnt_d;

    // Reference model: one queue of pending words and one delivery count per lane.
    logic [31:0] mq   [4][$];
    logic [15:0] mcnt [4];
    logic        last_ready;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(mq[i].size() != 0));
            if (mq[i].size() != 0) begin
                check($sformatf("head[%0d]", i), dout[i], mq[i][0]);
            end
            check($sformatf("cnt[%0d]", i), 32'(dcnt[i]), 32'(mcnt[i]));
        end
    endtask

    // One cycle: check registered state, drive inputs, check in_ready, advance model and clock.
    task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
        logic exp_ready;
        logic [3:0] pops;
        check_state();
        in_valid  = v;
        select    = s;
        in_data   = d;
        out_ready = r;
        #1;
        exp_ready = (mq[s].size() < 2);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        last_ready = in_ready;
        for (int i = 0; i < 4; i++) begin
            pops[i] = (mq[i].size() != 0) && r[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (pops[i]) begin
                void'(mq[i].pop_front());
                mcnt[i] = mcnt[i] + 16'd1;
            end
        end
        if (v && exp_ready) begin
            mq[s].push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = $urandom;
        select    = 2'($urandom);
        out_ready = 4'hF;
        repeat (cycles) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            mcnt[i] = 16'd0;
        end
        check("rst out_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst out[%0d]", i), dout[i], 32'h0);
            check($sformatf("rst cnt[%0d]", i), 32'(dcnt[i]), 32'h0);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            select = 2'(s);
            #1;
            check($sformatf("rst in_ready sel%0d", s), 32'(in_ready), 32'h1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        select    = '0;
        out_ready = '0;
        @(posedge clk);
        #1;
        do_reset(2);

        // Single steer to lane c.
        step(1'b1, 2'b10, 32'hDEADBEEF, 4'b0000);
        check("steer out_valid", 32'(out_valid), 32'h4);
        check("steer out_c", out_c, 32'hDEADBEEF);
        step(1'b0, 2'b00, 32'h0, 4'b0100);
        check("steer cnt_c", 32'(cnt_c), 32'd1);
        check("steer drained", 32'(out_valid), 32'h0);

        // Backpressure on lane b while lane a still accepts.
        step(1'b1, 2'b01, 32'h1, 4'b0000);
        step(1'b1, 2'b01, 32'h2, 4'b0000);
        step(1'b1, 2'b01, 32'h3, 4'b0000);
        check("bp full b ready", 32'(last_ready), 32'h0);
        step(1'b1, 2'b00, 32'h3, 4'b0000);
        check("bp lane a ready", 32'(last_ready), 32'h1);
        check("bp out_a", out_a, 32'h3);
        // Pop at full does not raise ready in the same cycle.
        step(1'b1, 2'b01, 32'h4, 4'b0010);
        check("bp pop-full ready", 32'(last_ready), 32'h0);
        check("bp b second", out_b, 32'h2);
        step(1'b0, 2'b01, 32'h0, 4'b0011);
        check("bp drained", 32'(out_valid), 32'h0);

        // Back-to-back push/pop on lane d with occupancy held at 1.
        for (int k = 0; k < 100; k++) begin
            step(1'b1, 2'b11, 32'(k), 4'b1000);
            check("d occ1 valid", 32'(out_valid), 32'h8);
        end
        step(1'b0, 2'b11, 32'h0, 4'b1000);
        check("d cnt 100", 32'(cnt_d), 32'd100);

        // Reset with lanes a and c full discards their contents.
        step(1'b1, 2'b00, 32'hA0, 4'b0000);
        step(1'b1, 2'b00, 32'hA1, 4'b0000);
        step(1'b1, 2'b10, 32'hC0, 4'b0000);
        step(1'b1, 2'b10, 32'hC1, 4'b0000);
        check("pre-rst valid", 32'(out_valid), 32'h5);
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 2'b00, 32'h0, 4'hF);
            check("post-rst valid", 32'(out_valid), 32'h0);
        end

        // Counter wrap on lane a after 65536 deliveries.
        for (int k = 0; k < 65536; k++) begin
            step(1'b1, 2'b00, $urandom, 4'b0001);
        end
        step(1'b0, 2'b00, 32'h0, 4'b0001);
        check("wrap cnt_a", 32'(cnt_a), 32'h0);
        check("wrap cnt_b", 32'(cnt_b), 32'h0);
        check("wrap cnt_c", 32'(cnt_c), 32'h0);
        check("wrap cnt_d", 32'(cnt_d), 32'h0);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom), 2'($urandom), $urandom, 4'($urandom));
        end
        step(1'b0, 2'b00, 32'h0, 4'hF);
        step(1'b0, 2'b00, 32'h0, 4'hF);
        check_state();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
